// File: rtl/persiana_actuador.sv
// Blind motor actuator: start/reverse sequencing, position tracking and limit decode.
// Optional motor dead time before every start is enabled with macro PERSIANA_DEADTIME_EN.
module persiana_actuador #(
  parameter int STEP_DIV  = 16,
  parameter int POS_MAX   = 200,
  parameter int DEAD_TIME = 8,
  parameter int INIT_POS  = 0
) (
  input  logic       Reloj,
  input  logic       reset,
  input  logic       subir,
  input  logic       bajar,
  output logic       motor_arriba,
  output logic       motor_abajo,
  output logic       Ssup,
  output logic       Smed,
  output logic       Sinf,
  output logic [7:0] posicion,
  output logic       conflicto,
  output logic [1:0] estado
);

`ifdef PERSIANA_DEADTIME_EN
  localparam bit USE_DEAD = 1'b1;
`else
  localparam bit USE_DEAD = 1'b0;
`endif

  localparam int PW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TIME - 1);
  localparam logic [7:0]    PMAX       = 8'(POS_MAX);
  localparam logic [7:0]    PMID       = 8'(POS_MAX / 2);
  localparam logic [7:0]    PINIT      = 8'(INIT_POS);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ESPERA   = 2'd1,
    SUBIENDO = 2'd2,
    BAJANDO  = 2'd3
  } estado_t;

  // Without dead time the start state is the motion state itself.
  localparam estado_t START_UP   = USE_DEAD ? ESPERA : SUBIENDO;
  localparam estado_t START_DOWN = USE_DEAD ? ESPERA : BAJANDO;

  estado_t         estado_q, estado_d;
  logic            dir_q, dir_d;          // 1 = up
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [7:0]      pos_q, pos_d;
  logic            conf_q;

  always_ff @(posedge Reloj or negedge reset) begin
    if (!reset) begin
      estado_q <= PARADO;
      dir_q    <= 1'b0;
      presc_q  <= '0;
      dcnt_q   <= '0;
      pos_q    <= PINIT;
      conf_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      dir_q    <= dir_d;
      presc_q  <= presc_d;
      dcnt_q   <= dcnt_d;
      pos_q    <= pos_d;
      conf_q   <= subir & bajar;
    end
  end

  always_comb begin
    estado_d = estado_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    dcnt_d   = dcnt_q;
    pos_d    = pos_q;
    if (subir && bajar) begin
      estado_d = PARADO;
    end else begin
      case (estado_q)
        PARADO: begin
          if (subir && pos_q != PMAX) begin
            dir_d    = 1'b1;
            estado_d = START_UP;
          end else if (bajar && pos_q != 8'd0) begin
            dir_d    = 1'b0;
            estado_d = START_DOWN;
          end
        end
        ESPERA: begin
          if (dir_q ? (!subir || pos_q == PMAX) : (!bajar || pos_q == 8'd0))
            estado_d = PARADO;
          else if (dcnt_q == DEAD_LAST)
            estado_d = dir_q ? SUBIENDO : BAJANDO;
          else
            dcnt_d = dcnt_q + 1'b1;
        end
        SUBIENDO: begin
          if (subir) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              pos_d   = pos_q + 8'd1;
              if (pos_d == PMAX) estado_d = PARADO;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end else if (bajar && pos_q != 8'd0) begin
            dir_d    = 1'b0;
            estado_d = START_DOWN;
          end else begin
            estado_d = PARADO;
          end
        end
        BAJANDO: begin
          if (bajar) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              pos_d   = pos_q - 8'd1;
              if (pos_d == 8'd0) estado_d = PARADO;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end else if (subir && pos_q != PMAX) begin
            dir_d    = 1'b1;
            estado_d = START_UP;
          end else begin
            estado_d = PARADO;
          end
        end
        default: estado_d = PARADO;
      endcase
    end
    // Any state change discards partial step and dead-time progress.
    if (estado_d != estado_q) begin
      presc_d = '0;
      dcnt_d  = '0;
    end
  end

  assign motor_arriba = (estado_q == SUBIENDO);
  assign motor_abajo  = (estado_q == BAJANDO);
  assign posicion     = pos_q;
  assign Ssup         = (pos_q == PMAX);
  assign Smed         = (pos_q == PMID);
  assign Sinf         = (pos_q == 8'd0);
  assign conflicto    = conf_q;
  assign estado       = estado_q;

endmodule

// File: tb/tb_persiana_actuador.sv
// Directed bench for persiana_actuador: expected outputs are queued with the cycle they
// are due on and compared when the walk reaches that cycle.
module tb_persiana_actuador;

  localparam int SD = 4;
  localparam int PM = 20;
`ifdef PERSIANA_DEADTIME_EN
  localparam int DT = 3;
`else
  localparam int DT = 0;
`endif
  localparam int P2 = PM - (9 - DT) / SD;

  logic       Reloj;
  logic       reset;
  logic       subir;
  logic       bajar;
  logic       motor_arriba;
  logic       motor_abajo;
  logic       Ssup;
  logic       Smed;
  logic       Sinf;
  logic [7:0] posicion;
  logic       conflicto;
  logic [1:0] estado;

  persiana_actuador #(
    .STEP_DIV (SD),
    .POS_MAX  (PM),
    .DEAD_TIME(3),
    .INIT_POS (0)
  ) dut (
    .Reloj       (Reloj),
    .reset       (reset),
    .subir       (subir),
    .bajar       (bajar),
    .motor_arriba(motor_arriba),
    .motor_abajo (motor_abajo),
    .Ssup        (Ssup),
    .Smed        (Smed),
    .Sinf        (Sinf),
    .posicion    (posicion),
    .conflicto   (conflicto),
    .estado      (estado)
  );

  // clock / reset
  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  // scoreboard
  logic [13:0] exp_q[$];
  int          cyc_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;
  int          jj    = 0;

  // {motor_arriba, motor_abajo, Ssup, Smed, Sinf, conflicto, posicion}
  function automatic logic [13:0] mk(logic ma, logic mb, int pos, logic conf);
    return {ma, mb, pos == PM, pos == PM / 2, pos == 0, conf, 8'(pos)};
  endfunction

  task automatic want(int c, string tag, logic [13:0] e);
    cyc_q.push_back(c);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic goto_cyc(int t);
    if (t > jj) repeat (t - jj) @(negedge Reloj);
    jj = t;
  endtask

  task automatic drain();
    int          c;
    string       t;
    logic [13:0] e;
    logic [13:0] obs;
    while (exp_q.size() > 0) begin
      c = cyc_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      goto_cyc(c);
      obs = {motor_arriba, motor_abajo, Ssup, Smed, Sinf, conflicto, posicion};
      total++;
      assert (obs === e)
      else begin
        bad++;
        $error("FAIL %s: got=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // driver: linear directed sequence, inputs change on the falling edge
  initial begin
    reset = 1'b0;
    subir = 1'b0;
    bajar = 1'b0;
    jj = 0;
    want(2, "reset_state", mk(0, 0, 0, 0));
    drain();

    // full travel up with subir held
    @(negedge Reloj);
    reset = 1'b1; subir = 1'b1; jj = 0;
    want(DT,                 "up_dead",     mk(0, 0, 0, 0));
    want(DT + 1,             "up_motor_on", mk(1, 0, 0, 0));
    want(DT + SD,            "up_prestep",  mk(1, 0, 0, 0));
    want(DT + SD + 1,        "up_pos1",     mk(1, 0, 1, 0));
    want(DT + 1 + 10 * SD,   "up_mid",      mk(1, 0, 10, 0));
    want(DT + 11 * SD,       "up_mid_hold", mk(1, 0, 10, 0));
    want(DT + 1 + 11 * SD,   "up_mid_off",  mk(1, 0, 11, 0));
    want(DT + 20 * SD,       "up_pre_top",  mk(1, 0, 19, 0));
    want(DT + 1 + 20 * SD,   "up_top",      mk(0, 0, 20, 0));
    want(DT + 6 + 20 * SD,   "up_top_hold", mk(0, 0, 20, 0));
    drain();

    // bajar for 10 edges from the top, then release
    subir = 1'b0; bajar = 1'b1; jj = 0;
    want(DT,          "dn_dead",    mk(0, 0, 20, 0));
    want(DT + 1,      "dn_on",      mk(0, 1, 20, 0));
    want(DT + SD,     "dn_prestep", mk(0, 1, 20, 0));
    want(DT + SD + 1, "dn_pos19",   mk(0, 1, 19, 0));
    want(10,          "dn_last",    mk(0, 1, P2, 0));
    drain();
    bajar = 1'b0;
    want(11, "dn_release", mk(0, 0, P2, 0));
    want(14, "dn_held",    mk(0, 0, P2, 0));
    drain();

    // down to the bottom limit and stay there with bajar still held
    bajar = 1'b1; jj = 0;
    want(DT + 1,           "bot_on",   mk(0, 1, P2, 0));
    want(DT + SD * P2,     "bot_pos1", mk(0, 1, 1, 0));
    want(DT + 1 + SD * P2, "bot_stop", mk(0, 0, 0, 0));
    want(DT + 4 + SD * P2, "bot_hold", mk(0, 0, 0, 0));
    drain();

    // up to 5, then reverse
    bajar = 1'b0; subir = 1'b1; jj = 0;
    want(DT + 1 + 5 * SD, "rv_pos5", mk(1, 0, 5, 0));
    drain();
    subir = 1'b0; bajar = 1'b1; jj = 0;
    want(DT,          "rv_dead",    mk(1'(DT == 0), 0, 5, 0));
    want(DT + 1,      "rv_on",      mk(0, 1, 5, 0));
    want(DT + SD,     "rv_prestep", mk(0, 1, 5, 0));
    want(DT + SD + 1, "rv_pos4",    mk(0, 1, 4, 0));
    drain();

    // reverse to up, then both commands together
    bajar = 1'b0; subir = 1'b1; jj = 0;
    want(DT + 1, "cf_moving", mk(1, 0, 4, 0));
    drain();
    bajar = 1'b1; jj = 0;
    want(1, "cf_set",  mk(0, 0, 4, 1));
    want(3, "cf_hold", mk(0, 0, 4, 1));
    drain();
    bajar = 1'b0; jj = 0;
    want(1,               "cf_clear", mk(1'(DT == 0), 0, 4, 0));
    want(1 + DT + 8 * SD, "rs_pos12", mk(1, 0, 12, 0));
    drain();

    // asynchronous reset in mid-motion, observed before any clock edge
    #2 reset = 1'b0;
    #1;
    want(jj, "rs_async", mk(0, 0, 0, 0));
    drain();
    @(negedge Reloj);
    reset = 1'b1; subir = 1'b0; jj = 0;
    want(2, "rs_after", mk(0, 0, 0, 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

endmodule
